// File: rtl/serial_pkg.sv
// serial_pkg: shared serial line definitions
// tx state encoding and parity modes
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // x is the xor of all data bits
  function automatic logic par_bit(
    input logic x,
    input int   mode
  );
    return (mode == PAR_EVEN) ? x : ~x;
  endfunction

endpackage

// File: rtl/serial_tx_cfg_if.sv
// serial_tx_cfg_if: producer-side bus of the transmitter
// push strobe, flow control and the serial line
interface serial_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx;
  logic                 block;
  logic                 busy;
  logic                 idle;
  logic [DATA_BITS-1:0] data;
  logic                 new_data;

  modport master (
    output block,
    output data,
    output new_data,
    input  tx,
    input  busy,
    input  idle
  );

  modport slave (
    input  block,
    input  data,
    input  new_data,
    output tx,
    output busy,
    output idle
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth
// push when full is accepted only together with a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign full  = (r_cnt == L_FULL);
  assign empty = (r_cnt == '0);
  assign w_rd  = rd_en & ~empty;
  assign w_wr  = wr_en & (~full | w_rd);
  assign dout  = r_mem[r_rp];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr)
                     - (AW+1)'(w_rd);
    end
  end

  // storage, contents don't matter after reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/serial_tx_cfg.sv
// serial_tx_cfg: configurable UART-style transmitter
// FIFO-buffered frames with parity and stop options
module serial_tx_cfg
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_tx_cfg_if.slave bus
);
  localparam int CW = $clog2(CLK_PER_BIT*STOP_BITS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] L_BIT_END =
    CW'(CLK_PER_BIT-1);
  localparam logic [CW-1:0] L_STOP_END =
    CW'(CLK_PER_BIT*STOP_BITS-1);
  localparam logic [BW-1:0] L_LAST_BIT =
    BW'(DATA_BITS-1);

  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("DATA_BITS must be 5..9");
  end
  if (CLK_PER_BIT < 2) begin : g_bad_cpb
    $error("CLK_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_t            r_state;
  tx_state_t            w_state_n;
  logic [CW-1:0]        r_cyc;
  logic [CW-1:0]        w_cyc_n;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_n;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_n;
  logic                 r_tx;
  logic                 w_tx_n;
  logic                 r_block_q;
  logic                 r_idle;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_dout;
  logic                 w_full;
  logic                 w_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (bus.new_data),
    .din   (bus.data),
    .rd_en (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.tx   = r_tx;
  assign bus.busy = w_full | r_block_q;
  assign bus.idle = r_idle;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  // next state, counters, pop and line level
  always_comb begin
    w_state_n = r_state;
    w_cyc_n   = r_cyc + CW'(1);
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    w_tx_n    = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_cyc_n = '0;
        if (!w_empty && !r_block_q) begin
          w_pop     = 1'b1;
          w_shift_n = w_dout;
          w_bit_n   = '0;
          w_state_n = ST_START;
        end
      end
      ST_START: begin
        w_tx_n = 1'b0;
        if (r_cyc == L_BIT_END) begin
          w_cyc_n   = '0;
          w_state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx_n = r_shift[r_bit];
        if (r_cyc == L_BIT_END) begin
          w_cyc_n = '0;
          if (r_bit == L_LAST_BIT) begin
            w_state_n = (PARITY != PAR_NONE) ?
                        ST_PAR : ST_STOP;
          end else begin
            w_bit_n = r_bit + BW'(1);
          end
        end
      end
      ST_PAR: begin
        w_tx_n = par_bit(^r_shift, PARITY);
        if (r_cyc == L_BIT_END) begin
          w_cyc_n   = '0;
          w_state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cyc == L_STOP_END) begin
          w_cyc_n   = '0;
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // datapath and registered flags; tx lags state by one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_block_q <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_cyc     <= w_cyc_n;
      r_bit     <= w_bit_n;
      r_shift   <= w_shift_n;
      r_tx      <= w_tx_n;
      r_block_q <= bus.block;
      r_idle    <= (w_state_n == ST_IDLE) &&
                   w_empty && !bus.new_data;
    end
  end
endmodule

// File: tb/tb_serial_tx_cfg.sv
// tb_serial_tx_cfg: three configurations of serial_tx_cfg
// tx waveform checked against a frame-level model
module tb_serial_tx_cfg;
  import serial_pkg::*;

  localparam int MAXC = 6000;
  localparam int NI   = 3;
  localparam int DEP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  serial_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  serial_tx_cfg_if #(.DATA_BITS(5)) if2 ();

  serial_tx_cfg #(
    .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(PAR_NONE),
    .STOP_BITS(1), .FIFO_DEPTH(DEP)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));

  serial_tx_cfg #(
    .CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(PAR_EVEN),
    .STOP_BITS(1), .FIFO_DEPTH(DEP)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  serial_tx_cfg #(
    .CLK_PER_BIT(4), .DATA_BITS(5), .PARITY(PAR_ODD),
    .STOP_BITS(2), .FIFO_DEPTH(DEP)
  ) u2 (.clk(clk), .rst(rst), .bus(if2));

  int cpb [NI] = '{4, 4, 4};
  int db  [NI] = '{8, 8, 5};
  int par [NI] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
  int stp [NI] = '{1, 1, 2};

  logic lg [NI][MAXC];
  logic ex [NI][MAXC];
  int   sq [NI][$];
  int   hold [NI];
  int   cyc;
  int   total;
  int   bad;

  function automatic int flen(input int k);
    return (1 + db[k] + ((par[k] != 0) ? 1 : 0) + stp[k]) * cpb[k];
  endfunction

  function automatic logic tx_of(input int k);
    case (k)
      0:       return if0.tx;
      1:       return if1.tx;
      default: return if2.tx;
    endcase
  endfunction

  function automatic logic busy_of(input int k);
    case (k)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic idle_of(input int k);
    case (k)
      0:       return if0.idle;
      1:       return if1.idle;
      default: return if2.idle;
    endcase
  endfunction

  function automatic int first_low(input int k, input int from);
    for (int i = from; i <= cyc && i < MAXC; i++)
      if (lg[k][i] === 1'b0) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc < MAXC) begin
      lg[0][cyc] = if0.tx;
      lg[1][cyc] = if1.tx;
      lg[2][cyc] = if2.tx;
    end
    if0.new_data = 1'b0;
    if1.new_data = 1'b0;
    if2.new_data = 1'b0;
  endtask

  task automatic run_to(input int idx);
    while (cyc < idx) tick();
  endtask

  // expected line levels of one frame starting at index s
  task automatic frame_exp(input int k, input int w, input int s);
    logic b [$];
    int   ones;
    b.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < db[k]; i++) begin
      b.push_back(w[i]);
      ones += w[i];
    end
    if (par[k] == PAR_EVEN) b.push_back((ones % 2) == 1);
    if (par[k] == PAR_ODD)  b.push_back((ones % 2) == 0);
    for (int i = 0; i < stp[k]; i++) b.push_back(1'b1);
    for (int i = 0; i < b.size(); i++)
      for (int c = 0; c < cpb[k]; c++)
        if (s + i*cpb[k] + c < MAXC)
          ex[k][s + i*cpb[k] + c] = b[i];
  endtask

  // push at the next edge t: returns start index or -1 if dropped
  task automatic model_push(input int k, input int w, output int s);
    int t, cnt, last;
    bit popt;
    t = cyc + 1;
    cnt = 0;
    popt = 0;
    last = -1000;
    foreach (sq[k][i]) begin
      if (sq[k][i] - 1 >= t) cnt++;
      if (sq[k][i] - 1 == t) popt = 1;
      last = sq[k][i];
    end
    if (cnt >= DEP && !popt) begin
      s = -1;
    end else begin
      s = t + 2;
      if (last + flen(k) + 1 > s) s = last + flen(k) + 1;
      if (hold[k] > s) s = hold[k];
      sq[k].push_back(s);
      frame_exp(k, w, s);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      sq[k].delete();
      hold[k] = 0;
      for (int i = cyc + 1; i < MAXC; i++) ex[k][i] = 1'b1;
    end
  endtask

  task automatic push(input int k, input int w, output int s);
    case (k)
      0: begin if0.data = w[7:0]; if0.new_data = 1'b1; end
      1: begin if1.data = w[7:0]; if1.new_data = 1'b1; end
      default: begin if2.data = w[4:0]; if2.new_data = 1'b1; end
    endcase
    model_push(k, w, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s1, s2, sd, pe, r_edge, thr;
    int sv [6];
    int w3 [6] = '{8'h11, 8'h82, 8'h3C, 8'hF0, 8'h5A, 8'h77};
    total = 0;
    bad = 0;
    cyc = 0;
    for (int k = 0; k < NI; k++) begin
      hold[k] = 0;
      for (int i = 0; i < MAXC; i++) ex[k][i] = 1'b1;
    end
    if0.new_data = 1'b0; if0.block = 1'b0; if0.data = '0;
    if1.new_data = 1'b0; if1.block = 1'b0; if1.data = '0;
    if2.new_data = 1'b0; if2.block = 1'b0; if2.data = '0;

    // reset state
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_tx%0d", k), 32'(tx_of(k)), 1);
      chk($sformatf("rst_busy%0d", k), 32'(busy_of(k)), 0);
      chk($sformatf("rst_idle%0d", k), 32'(idle_of(k)), 1);
    end
    rst = 1'b0;
    tick();

    // single 8N1 frame of 0xA5
    pe = cyc + 1;
    push(0, 'hA5, s);
    tick();
    chk("t1_idle_drop", 32'(idle_of(0)), 0);
    run_to(pe + 2 + 40 - 2);
    chk("t1_idle_in_stop", 32'(idle_of(0)), 0);
    tick();
    chk("t1_idle_end", 32'(idle_of(0)), 1);
    run_to(pe + 50);
    chk("t1_latency", first_low(0, pe), pe + 2);
    chk("t1_bit0", 32'(lg[0][pe + 6]), 1);
    chk("t1_bit1", 32'(lg[0][pe + 10]), 0);
    chk("t1_bit7", 32'(lg[0][pe + 34]), 1);
    chk("t1_stop", 32'(lg[0][pe + 38]), 1);

    // parity: even 0x55 and odd 0x15
    pe = cyc + 1;
    push(1, 'h55, s1);
    push(2, 'h15, s2);
    tick();
    run_to(pe + 50);
    chk("t2_even_55", 32'(lg[1][pe + 2 + 36]), 0);
    chk("t2_odd_15", 32'(lg[2][pe + 2 + 24]), 0);
    pe = cyc + 1;
    push(1, 'h07, s1);
    tick();
    run_to(pe + 50);
    chk("t2_even_07", 32'(lg[1][pe + 2 + 36]), 1);

    // 5O2 corner: 0x1F, 36-clk frame
    pe = cyc + 1;
    push(2, 'h1F, s2);
    tick();
    run_to(pe + 2 + 34);
    chk("t6_idle_in_stop", 32'(idle_of(2)), 0);
    tick();
    chk("t6_idle_end", 32'(idle_of(2)), 1);
    run_to(pe + 45);
    chk("t6_latency", first_low(2, pe), pe + 2);
    chk("t6_par", 32'(lg[2][pe + 2 + 24]), 0);
    chk("t6_stop2", 32'(lg[2][pe + 2 + 35]), 1);

    // queueing and overflow: six pushes back to back
    pe = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      push(0, w3[i], sv[i]);
      tick();
      if (i == 4) chk("t3_busy_full", 32'(busy_of(0)), 1);
    end
    run_to(pe + 2 + 41 - 2);
    chk("t3_busy_hold", 32'(busy_of(0)), 1);
    tick();
    chk("t3_busy_free", 32'(busy_of(0)), 0);
    run_to(pe + 2 + 5*41 + 5);
    chk("t3_idle_after", 32'(idle_of(0)), 1);

    // block mid-frame holds the queued word
    pe = cyc + 1;
    push(0, 'h3C, s);
    tick();
    run_to(pe + 2 + 10);
    r_edge = pe + 2 + 60;
    if0.block = 1'b1;
    hold[0] = r_edge + 2;
    tick();
    chk("t4_busy_block", 32'(busy_of(0)), 1);
    push(0, 'hC3, s);
    tick();
    run_to(r_edge - 1);
    chk("t4_busy_held", 32'(busy_of(0)), 1);
    chk("t4_idle_held", 32'(idle_of(0)), 0);
    if0.block = 1'b0;
    hold[0] = 0;
    tick();
    chk("t4_busy_release", 32'(busy_of(0)), 0);
    run_to(r_edge + 50);
    chk("t4_restart", first_low(0, pe + 2 + 40), r_edge + 2);

    // reset during data bit 3
    pe = cyc + 1;
    push(0, 'h5A, s);
    tick();
    push(0, 'h99, sd);
    tick();
    run_to(pe + 2 + 16);
    rst = 1'b1;
    model_reset();
    tick();
    chk("t5_tx", 32'(tx_of(0)), 1);
    chk("t5_busy", 32'(busy_of(0)), 0);
    chk("t5_idle", 32'(idle_of(0)), 1);
    rst = 1'b0;
    run_to(cyc + 100);
    chk("t5_quiet", first_low(0, cyc - 99), -1);

    // random traffic with bursts that overrun the FIFO
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < NI; k++) begin
        thr = ((n % 300) < 40) ? 8 : 2;
        if ($urandom_range(9, 0) < thr)
          push(k, int'($urandom_range(511, 0)), sd);
      end
      tick();
    end
    run_to(cyc + 300);
    for (int k = 0; k < NI; k++)
      chk($sformatf("rnd_idle%0d", k), 32'(idle_of(k)), 1);

    // whole-run line waveform against the model
    for (int k = 0; k < NI; k++)
      for (int i = 1; i <= cyc && i < MAXC; i++)
        chk($sformatf("tx%0d_at_%0d", k, i),
            32'(lg[k][i]), 32'(ex[k][i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_tx_cfg.md
Name: serial_tx_cfg

Overview:
Parametrised UART-style transmitter, successor to the fixed 8N1 serial transmitter.
- Configurable data width, parity mode, stop-bit count and bit period.
- Small transmit FIFO, so producers can queue bytes back-to-back.
- Sits between on-chip producers (command/telemetry logic) and the tx pin; keeps the block/busy flow-control contract.

Parameters:
CLK_PER_BIT, 50, clock cycles per serial bit (>=2)
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, transmit FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx  out  1  serial line, idle high
block  in  1  inhibit start of new frames (e.g. downstream not ready)
busy  out  1  high when new_data will not be accepted
idle  out  1  high when FIFO empty, state IDLE and no frame in progress
data  in  DATA_BITS  word to transmit
new_data  in  1  push strobe; data sampled at the same edge

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: tx=1, busy=0 (block_q cleared), idle=1, FIFO empty, state IDLE, counters 0.
- Reset mid-frame aborts the frame. tx returns high at the reset edge and FIFO contents are discarded.
- block is registered (block_q, 1-cycle delay).
- busy = fifo_full | block_q, registered output.
- Push: new_data & !fifo_full writes data at that edge. block does not inhibit pushes.
- Push when full is dropped silently. FIFO contents and the current frame are unaffected.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: tx=1. If FIFO non-empty and !block_q: pop the head into shift register, clear counters, go to START.
- START: tx=0 for CLK_PER_BIT cycles, then DATA.
- DATA: tx=shift[bit_ctr] for CLK_PER_BIT cycles per bit, bit_ctr 0..DATA_BITS-1. After the last bit go to PAR if PARITY!=0, else STOP.
- PAR: tx = ^word for even parity, ~^word for odd, held CLK_PER_BIT cycles. Result: total ones in data+parity is even/odd respectively.
- STOP: tx=1 for STOP_BITS*CLK_PER_BIT cycles, then IDLE.
- Back-to-back frames: IDLE may pop on its first cycle, so the inter-frame gap is exactly 1 clk of idle-high beyond the stop bits.
- block_q asserted mid-frame never truncates the frame; it only holds the next frame in IDLE.
- Latency: FIFO and FSM idle, new_data at edge E0 -> pop at E1 -> tx low from E2.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_PER_BIT cycles.
- Counters: cycle counter width $clog2(CLK_PER_BIT*STOP_BITS); bit counter width $clog2(DATA_BITS). Both compared, never wrapped.
- Simultaneous push and pop in the same cycle is legal at any occupancy, including full (pop frees a slot; push accepted).
- Simultaneous push and pop on an empty FIFO is not possible: push data becomes visible the next cycle.
- idle is registered; it drops the cycle after a push is accepted.
- Illegal parameters (PARITY>2, STOP_BITS not 1/2, DATA_BITS out of range) fail elaboration via generate-time check.

Decomposition:
- Package serial_pkg: tx state encoding (IDLE/START/DATA/PAR/STOP) and parity-mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2). Shared with a future parametrised receiver.
- Sub-module sync_fifo: params WIDTH, DEPTH; ports clk, rst, wr_en, din, rd_en, dout, full, empty.
- FSM, counters and parity generation stay in serial_tx_cfg.

Test Plan:
1. Single frame (CLK_PER_BIT=4, 8N1): push 0xA5 -> tx low from E2 for 4 clks, then bits 1,0,1,0,0,1,0,1 each 4 clks, stop high 4 clks; idle=1 at frame end.
2. Parity (PARITY=2, then PARITY=1): push 0x55 -> parity bit 0 for even, 1 for odd. Push 0x07 -> even parity bit 1.
3. Queueing/overflow (FIFO_DEPTH=4): push 6 words in consecutive cycles -> busy high once full; 6th push dropped; exactly 5 frames out (first popped early) with 1-clk gaps; order preserved.
4. Block: assert block mid-frame -> current frame completes intact; queued word not started until 1 clk after block deasserts (+ pipeline); busy high while block_q high.
5. Reset mid-frame: rst pulse during DATA bit 3 -> tx=1 the next cycle; FIFO empty; busy=0; idle=1; no further frames.
6. Config corners (DATA_BITS=5, STOP_BITS=2, PARITY=1): push 0x1F -> 5 data bits of 1, parity 0, stop high 8 clks; total frame 36 clks.
